multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OP_W, default 4, opcode width taken from IR[15:12].
REQ-002 SHALL have parameter ALUOP_W, default 3, ALU operation select width.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port opcode, input, OP_W bits: current IR opcode.
REQ-006 SHALL have port alu_zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory completes the current access this cycle.
REQ-008 SHALL have ports pc_write, ir_write, ab_write, aluout_write, mdr_write and reg_write, each output, 1 bit: datapath register load enables.
REQ-009 SHALL have ports mem_read and mem_write, each output, 1 bit: memory strobes.
REQ-010 SHALL have port iord, output, 1 bit: memory address select (0 = PC, 1 = ALUOut).
REQ-011 SHALL have ports mem_to_reg and alu_src_a, each output, 1 bit: writeback select (1 = MDR) and ALU A select (0 = PC, 1 = A).
REQ-012 SHALL have port alu_src_b, output, 2 bits: 0 = B, 1 = const 1, 2 = sign-extended imm, 3 = branch offset.
REQ-013 SHALL have port alu_op, output, ALUOP_W bits: 0 = add, 1 = sub, 7 = funct-decode.
REQ-014 SHALL have port pc_src, output, 2 bits: 0 = ALU result, 1 = ALUOut, 2 = jump target.
REQ-015 SHALL have ports halted and illegal, each output, 1 bit, plus port state, output, 4 bits, for debug.

Function
REQ-016 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH, JUMP and HALT.
REQ-017 SHALL, in FETCH, hold mem_read=1 and iord=0 until mem_ready, and in the mem_ready cycle assert ir_write, pc_write, alu_src_a=0, alu_src_b=1 and alu_op=0 (PC+1), then move to DECODE.
REQ-018 SHALL, in DECODE, assert ab_write and aluout_write with alu_src_b=3 (precomputed branch target), then dispatch on opcode.
REQ-019 SHALL dispatch opcodes as: 0 -> EXEC_R; 1 -> EXEC_I; 2 or 3 -> ADDR; 4 or 5 -> BRANCH; 6 -> JUMP; 15 -> HALT.
REQ-020 SHALL treat every other opcode as illegal: return to FETCH and pulse illegal for exactly one cycle.
REQ-021 SHALL, in EXEC_R, drive alu_src_a=1, alu_src_b=0, alu_op=7 and aluout_write, then go to WB_R.
REQ-022 SHALL, in EXEC_I, do the same as EXEC_R but with alu_src_b=2 and alu_op=0, then go to WB_R.
REQ-023 SHALL, in WB_R, assert reg_write with mem_to_reg=0, then go to FETCH.
REQ-024 SHALL, in ADDR, compute A+imm into ALUOut, then go to MEM_RD for opcode 2 or MEM_WR for opcode 3.
REQ-025 SHALL, in MEM_RD, hold mem_read=1 and iord=1 until mem_ready, assert mdr_write in the mem_ready cycle, then go to WB_MEM.
REQ-026 SHALL, in WB_MEM, assert reg_write with mem_to_reg=1, then go to FETCH.
REQ-027 SHALL, in MEM_WR, hold mem_write=1 and iord=1 until mem_ready, then go to FETCH.
REQ-028 SHALL, in BRANCH, drive alu_op=1 (A-B) and pc_src=1, and assert pc_write iff (opcode 4 and alu_zero=1) or (opcode 5 and alu_zero=0), then go to FETCH.
REQ-029 SHALL, in JUMP, assert pc_write with pc_src=2, then go to FETCH.
REQ-030 SHALL, in HALT, assert halted, keep all enables and strobes 0, and remain in HALT until reset.
REQ-031 SHALL hold every write enable and strobe at 0 in any state where it is not explicitly asserted; the mem_ready-gated enables are Mealy, all other outputs are decoded from state.
REQ-032 SHALL give cycle counts with zero wait states of: R/I = 4, LW = 5, SW = 4, branch = 3, jump = 3.
REQ-033 SHALL extend each wait state on FETCH, MEM_RD or MEM_WR by exactly one cycle.

Reset
REQ-034 SHALL, on RST_N=0, immediately force the state to FETCH and every output to 0, independent of CLK, including mid-access.
REQ-035 SHALL, after reset deasserts, assert mem_read on the first cycle; no partial write may complete.

Structure
REQ-036 SHALL place the state encoding (4-bit), opcode constants, alu_op and pc_src codes in the shared package mc_pkg.
REQ-037 SHALL isolate the output decode in one sub-module, mc_out_decode (state, opcode, alu_zero, mem_ready -> controls); next-state logic and the state register stay in the top module.

Verification
REQ-038 SHALL cover: reset, then opcode=0, mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_R, FETCH, with reg_write high only in the 4th cycle.
REQ-039 SHALL cover: LW (opcode 2) with mem_ready low for 2 cycles in MEM_RD -> mem_read held for 3 cycles, mdr_write pulses once, 7 cycles total.
REQ-040 SHALL cover: BEQ with alu_zero=1 -> pc_write=1, pc_src=1 in BRANCH; BNE with alu_zero=1 -> pc_write=0.
REQ-041 SHALL cover: opcode 9 -> illegal pulses one cycle, back to FETCH, no reg_write, mem_write or pc_write after DECODE.
REQ-042 SHALL cover: RST_N dropped mid MEM_WR -> mem_write=0 asynchronously; after release state=FETCH with mem_read=1.
REQ-043 SHALL cover: opcode 15 -> halted=1 and held for 20 cycles with every strobe 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcode map,
// ALU/PC select codes and the control bundle produced by the output decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ITYPE = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_BNE   = 4'd5;
  localparam logic [3:0] OP_JMP   = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd7;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFF = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       ab_write;
    logic       aluout_write;
    logic       mdr_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
    logic       illegal;
  } ctl_t;

  // Opcode map out of DECODE; S_FETCH marks an illegal opcode.
  function automatic state_t dispatch(input logic [3:0] op);
    case (op)
      OP_RTYPE:       return S_EXEC_R;
      OP_ITYPE:       return S_EXEC_I;
      OP_LW, OP_SW:   return S_ADDR;
      OP_BEQ, OP_BNE: return S_BRANCH;
      OP_JMP:         return S_JUMP;
      OP_HALT:        return S_HALT;
      default:        return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Control decode: selects follow the state alone, while the memory-completion
// enables and the branch/illegal qualifiers also look at the live inputs.
module mc_out_decode
  import mc_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  state_t          state,
  input  logic [OP_W-1:0] opcode,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output ctl_t            ctl
);

  logic [3:0] op_s;
  assign op_s = 4'(opcode);

  // Per-state control decode
  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_ONE;
        ctl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
        end else begin
          ctl.ir_write = 1'b0;
          ctl.pc_write = 1'b0;
        end
      end
      S_DECODE: begin
        ctl.ab_write     = 1'b1;
        ctl.aluout_write = 1'b1;
        ctl.alu_src_b    = SRCB_BOFF;
        ctl.alu_op       = ALU_ADD;
        ctl.illegal      = (dispatch(op_s) == S_FETCH);
      end
      S_EXEC_R: begin
        ctl.alu_src_a    = 1'b1;
        ctl.alu_src_b    = SRCB_B;
        ctl.alu_op       = ALU_FUNCT;
        ctl.aluout_write = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        ctl.alu_src_a    = 1'b1;
        ctl.alu_src_b    = SRCB_IMM;
        ctl.alu_op       = ALU_ADD;
        ctl.aluout_write = 1'b1;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (mem_ready) begin
          ctl.mdr_write = 1'b1;
        end else begin
          ctl.mdr_write = 1'b0;
        end
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_WB_R: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b0;
      end
      S_WB_MEM: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_src    = PC_ALUOUT;
        if ((op_s == OP_BEQ && alu_zero) || (op_s == OP_BNE && !alu_zero)) begin
          ctl.pc_write = 1'b1;
        end else begin
          ctl.pc_write = 1'b0;
        end
      end
      S_JUMP: begin
        ctl.pc_write = 1'b1;
        ctl.pc_src   = PC_JUMP;
      end
      S_HALT: begin
        ctl.halted = 1'b1;
      end
      default: begin
        ctl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: state register and next-state logic; output
// decode lives in mc_out_decode and is forced quiet while reset is held.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int ALUOP_W = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [OP_W-1:0]    opcode,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               ab_write,
  output logic               aluout_write,
  output logic               mdr_write,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               halted,
  output logic               illegal,
  output logic [3:0]         state
);

  state_t     state_r;
  ctl_t       ctl_s;
  ctl_t       ctl_q_s;
  logic [3:0] op_s;

  assign op_s = 4'(opcode);

  // State register with next-state selection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= S_FETCH;
    end else begin
      case (state_r)
        S_FETCH:  state_r <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: state_r <= dispatch(op_s);
        S_EXEC_R: state_r <= S_WB_R;
        S_EXEC_I: state_r <= S_WB_R;
        S_ADDR:   state_r <= (op_s == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: state_r <= mem_ready ? S_WB_MEM : S_MEM_RD;
        S_MEM_WR: state_r <= mem_ready ? S_FETCH : S_MEM_WR;
        S_WB_R:   state_r <= S_FETCH;
        S_WB_MEM: state_r <= S_FETCH;
        S_BRANCH: state_r <= S_FETCH;
        S_JUMP:   state_r <= S_FETCH;
        S_HALT:   state_r <= S_HALT;
        default:  state_r <= S_FETCH;
      endcase
    end
  end

  mc_out_decode #(
    .OP_W(OP_W)
  ) u_out_decode (
    .state     (state_r),
    .opcode    (opcode),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .ctl       (ctl_s)
  );

  // FETCH decodes mem_read high, so reset must mask the bundle directly.
  assign ctl_q_s = RST_N ? ctl_s : '0;

  assign pc_write     = ctl_q_s.pc_write;
  assign ir_write     = ctl_q_s.ir_write;
  assign ab_write     = ctl_q_s.ab_write;
  assign aluout_write = ctl_q_s.aluout_write;
  assign mdr_write    = ctl_q_s.mdr_write;
  assign reg_write    = ctl_q_s.reg_write;
  assign mem_read     = ctl_q_s.mem_read;
  assign mem_write    = ctl_q_s.mem_write;
  assign iord         = ctl_q_s.iord;
  assign mem_to_reg   = ctl_q_s.mem_to_reg;
  assign alu_src_a    = ctl_q_s.alu_src_a;
  assign alu_src_b    = ctl_q_s.alu_src_b;
  assign alu_op       = ALUOP_W'(ctl_q_s.alu_op);
  assign pc_src       = ctl_q_s.pc_src;
  assign halted       = ctl_q_s.halted;
  assign illegal      = ctl_q_s.illegal;
  assign state        = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench: each instruction is expanded into its expected per-cycle trace from
// the instruction-level timing rules, then replayed and compared every cycle.
module tb_multicycle_control;

  localparam logic [3:0] T_FETCH  = 4'd0;
  localparam logic [3:0] T_DECODE = 4'd1;
  localparam logic [3:0] T_EXEC_R = 4'd2;
  localparam logic [3:0] T_EXEC_I = 4'd3;
  localparam logic [3:0] T_ADDR   = 4'd4;
  localparam logic [3:0] T_MEM_RD = 4'd5;
  localparam logic [3:0] T_MEM_WR = 4'd6;
  localparam logic [3:0] T_WB_R   = 4'd7;
  localparam logic [3:0] T_WB_MEM = 4'd8;
  localparam logic [3:0] T_BRANCH = 4'd9;
  localparam logic [3:0] T_JUMP   = 4'd10;
  localparam logic [3:0] T_HALT   = 4'd11;

  logic CLK = 1'b0;
  logic RST_N;
  logic [3:0] opcode;
  logic alu_zero, mem_ready;
  logic pc_write, ir_write, ab_write, aluout_write, mdr_write, reg_write;
  logic mem_read, mem_write, iord, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic halted, illegal;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic pc_write, ir_write, ab_write, aluout_write, mdr_write, reg_write;
    logic mem_read, mem_write, iord, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic halted, illegal;
  } obs_t;

  typedef struct {
    logic       rdy;
    logic [3:0] op;
    logic       zero;
    obs_t       o;
  } cyc_t;

  obs_t act, exp_o;
  logic exp_valid = 1'b0;
  cyc_t plan[$];
  int checks = 0, failures = 0;
  int cnt_cycles = 0, cnt_rw = 0, cnt_mrd = 0, cnt_mdr = 0, cnt_ill = 0, cnt_brpc = 0;

  assign act = {state, pc_write, ir_write, ab_write, aluout_write, mdr_write, reg_write,
                mem_read, mem_write, iord, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                pc_src, halted, illegal};

  multicycle_control #(.OP_W(4), .ALUOP_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .ab_write(ab_write), .aluout_write(aluout_write),
    .mdr_write(mdr_write), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .halted(halted), .illegal(illegal), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, a, e, $time);
    end
  endtask

  function automatic obs_t blank(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  task automatic push(input logic rdy, input logic [3:0] op, input logic zero, input obs_t o);
    cyc_t c;
    c.rdy = rdy; c.op = op; c.zero = zero; c.o = o;
    plan.push_back(c);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected trace of one instruction: fw fetch waits, mw memory waits.
  task automatic plan_instr(input logic [3:0] op, input logic zero, input int fw, input int mw);
    obs_t o;
    for (int i = 0; i <= fw; i++) begin
      o = blank(T_FETCH); o.mem_read = 1'b1; o.alu_src_b = 2'd1;
      o.ir_write = (i == fw); o.pc_write = (i == fw);
      push(i == fw, op, zero, o);
    end
    o = blank(T_DECODE); o.ab_write = 1'b1; o.aluout_write = 1'b1; o.alu_src_b = 2'd3;
    o.illegal = !(op <= 4'd6 || op == 4'd15);
    push(rb(), op, zero, o);
    if (op == 4'd0 || op == 4'd1) begin
      o = blank(op == 4'd0 ? T_EXEC_R : T_EXEC_I);
      o.alu_src_a = 1'b1; o.aluout_write = 1'b1;
      o.alu_src_b = (op == 4'd0) ? 2'd0 : 2'd2;
      o.alu_op = (op == 4'd0) ? 3'd7 : 3'd0;
      push(rb(), op, zero, o);
      o = blank(T_WB_R); o.reg_write = 1'b1;
      push(rb(), op, zero, o);
    end else if (op == 4'd2 || op == 4'd3) begin
      o = blank(T_ADDR); o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.aluout_write = 1'b1;
      push(rb(), op, zero, o);
      for (int i = 0; i <= mw; i++) begin
        o = blank(op == 4'd2 ? T_MEM_RD : T_MEM_WR); o.iord = 1'b1;
        if (op == 4'd2) begin
          o.mem_read = 1'b1; o.mdr_write = (i == mw);
        end else begin
          o.mem_write = 1'b1;
        end
        push(i == mw, op, zero, o);
      end
      if (op == 4'd2) begin
        o = blank(T_WB_MEM); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        push(rb(), op, zero, o);
      end
    end else if (op == 4'd4 || op == 4'd5) begin
      o = blank(T_BRANCH); o.alu_src_a = 1'b1; o.alu_op = 3'd1; o.pc_src = 2'd1;
      o.pc_write = (op == 4'd4) ? zero : !zero;
      push(rb(), op, zero, o);
    end else if (op == 4'd6) begin
      o = blank(T_JUMP); o.pc_write = 1'b1; o.pc_src = 2'd2;
      push(rb(), op, zero, o);
    end else if (op == 4'd15) begin
      o = blank(T_HALT); o.halted = 1'b1;
      push(rb(), op, zero, o);
    end
  endtask

  task automatic apply(input cyc_t c);
    mem_ready = c.rdy; opcode = c.op; alu_zero = c.zero;
    exp_o = c.o; exp_valid = 1'b1;
  endtask

  task automatic run_plan();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(negedge CLK);
      apply(c);
    end
    #3;
    exp_valid = 1'b0;
  endtask

  task automatic clr_cnt();
    cnt_cycles = 0; cnt_rw = 0; cnt_mrd = 0; cnt_mdr = 0; cnt_ill = 0; cnt_brpc = 0;
  endtask

  // Per-cycle compare against the planned trace
  always @(negedge CLK) begin
    #2;
    if (exp_valid) begin
      chk("cycle", 64'(act), 64'(exp_o));
      cnt_cycles++;
      if (reg_write) cnt_rw++;
      if (mem_read && state == T_MEM_RD) cnt_mrd++;
      if (mdr_write) cnt_mdr++;
      if (illegal) cnt_ill++;
      if (pc_write && state == T_BRANCH) cnt_brpc++;
    end
  end

  initial begin
    cyc_t c;
    RST_N = 1'b0; opcode = 4'd0; alu_zero = 1'b0; mem_ready = 1'b0;
    #3;
    chk("reset_outputs", 64'(act), 64'd0);
    @(negedge CLK);
    chk("reset_after_edge", 64'(act), 64'd0);
    mem_ready = 1'b0; RST_N = 1'b1;
    #1;
    chk("release_state", 64'(state), 64'(T_FETCH));
    chk("release_mem_read", 64'(mem_read), 64'd1);

    // R-type, zero wait: 4 cycles, reg_write only in the 4th
    plan_instr(4'd0, 1'b0, 0, 0);
    chk("model_r_len", 64'(plan.size()), 64'd4);
    chk("model_r_wb", 64'(plan[3].o.reg_write), 64'd1);
    clr_cnt(); run_plan();
    chk("r_cycles", 64'(cnt_cycles), 64'd4);
    chk("r_reg_write_cnt", 64'(cnt_rw), 64'd1);

    // LW with two wait states in MEM_RD
    plan_instr(4'd2, 1'b0, 0, 2);
    chk("model_lw_len", 64'(plan.size()), 64'd7);
    clr_cnt(); run_plan();
    chk("lw_mem_read_cycles", 64'(cnt_mrd), 64'd3);
    chk("lw_mdr_pulses", 64'(cnt_mdr), 64'd1);

    // BEQ taken, BNE not taken, both with alu_zero=1
    plan_instr(4'd4, 1'b1, 0, 0);
    chk("model_beq_pc_write", 64'(plan[2].o.pc_write), 64'd1);
    chk("model_beq_pc_src", 64'(plan[2].o.pc_src), 64'd1);
    clr_cnt(); run_plan();
    chk("beq_taken", 64'(cnt_brpc), 64'd1);
    plan_instr(4'd5, 1'b1, 1, 0);
    chk("model_bne_pc_write", 64'(plan[3].o.pc_write), 64'd0);
    clr_cnt(); run_plan();
    chk("bne_not_taken", 64'(cnt_brpc), 64'd0);

    // Illegal opcode 9: one-cycle pulse then straight back to FETCH
    plan_instr(4'd9, 1'b0, 0, 0);
    chk("model_ill_len", 64'(plan.size()), 64'd2);
    plan_instr(4'd1, 1'b0, 0, 0);
    clr_cnt(); run_plan();
    chk("illegal_pulses", 64'(cnt_ill), 64'd1);

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      plan_instr(4'($urandom_range(0, 14)), rb(), $urandom_range(0, 2), $urandom_range(0, 2));
      run_plan();
    end

    // Reset asserted while a store is waiting on memory
    plan_instr(4'd3, 1'b0, 0, 3);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(negedge CLK);
      apply(c);
      if (c.o.st == T_MEM_WR) break;
    end
    #4;
    exp_valid = 1'b0;
    chk("sw_mem_write_before_rst", 64'(mem_write), 64'd1);
    RST_N = 1'b0;
    #1;
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_all_zero", 64'(act), 64'd0);
    plan.delete();
    @(negedge CLK);
    mem_ready = 1'b0; RST_N = 1'b1;
    #1;
    chk("rerelease_state", 64'(state), 64'(T_FETCH));
    chk("rerelease_mem_read", 64'(mem_read), 64'd1);

    // HALT holds for 20 cycles with everything quiet
    plan_instr(4'd15, 1'b0, 0, 0);
    for (int i = 0; i < 19; i++) push(rb(), 4'($urandom_range(0, 15)), rb(), blank(T_HALT) | obs_t'(24'd2));
    clr_cnt(); run_plan();
    chk("halt_cycles", 64'(cnt_cycles), 64'd22);
    chk("halt_still", 64'(halted), 64'd1);
    RST_N = 1'b0;
    #1;
    chk("halt_reset", 64'(halted), 64'd0);
    @(negedge CLK);
    mem_ready = 1'b0; RST_N = 1'b1;

    plan_instr(4'd0, 1'b0, 1, 0);
    clr_cnt(); run_plan();
    chk("post_halt_r", 64'(cnt_rw), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
